// File: rtl/lcd_sign_render.sv
// Raster-order sign bitmap renderer: ROM address walk, 1-bit to RGB565 expansion, 2-entry output buffer.
// Optional 2x2 pixel replication when SIGN_SCALE2_EN is defined.
module lcd_sign_render #(
   parameter int unsigned IMG_W      = 320,
   parameter int unsigned IMG_H      = 240,
   parameter int unsigned ADDR_WIDTH = 17,
   parameter logic [15:0] FG_COLOR   = 16'hFFE0,
   parameter logic [15:0] BG_COLOR   = 16'h0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic                  rom_data,
   output logic [15:0]           pix_data,
   output logic                  pix_valid,
   input  logic                  pix_ready,
   output logic                  pix_last
);

   localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t                state_q, state_d;
   logic [XW-1:0]         x_q, x_d;
   logic [YW-1:0]         y_q, y_d;
   logic [ADDR_WIDTH-1:0] row_q, row_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
`ifdef SIGN_SCALE2_EN
   logic                  rx_q, rx_d;
   logic                  ry_q, ry_d;
`endif
   logic                  infl_q, infl_d;
   logic                  infl_last_q, infl_last_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [15:0]           d0_q, d0_d, d1_q, d1_d;
   logic                  l0_q, l0_d, l1_q, l1_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  pop, push, room, issue, x_end, y_end, at_last;
   logic [15:0]           push_data;

   assign x_end = (x_q == XW'(IMG_W - 1));
   assign y_end = (y_q == YW'(IMG_H - 1));
`ifdef SIGN_SCALE2_EN
   assign at_last = x_end & y_end & rx_q & ry_q;
`else
   assign at_last = x_end & y_end;
`endif

   assign pop       = (cnt_q != 2'd0) & pix_ready;
   assign push      = infl_q;
   assign push_data = rom_data ? FG_COLOR : BG_COLOR;
   // The read in flight must be counted, otherwise a stalled sink could overflow the buffer.
   assign room  = ({1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop}) < 3'd2;
   assign issue = (state_q == S_RUN) & room;

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      row_d       = row_q;
      addr_d      = addr_q;
`ifdef SIGN_SCALE2_EN
      rx_d        = rx_q;
      ry_d        = ry_q;
`endif
      infl_d      = issue;
      infl_last_d = issue & at_last;
      busy_d      = busy_q;
      done_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               busy_d  = 1'b1;
               x_d     = '0;
               y_d     = '0;
               row_d   = '0;
               addr_d  = '0;
`ifdef SIGN_SCALE2_EN
               rx_d    = 1'b0;
               ry_d    = 1'b0;
`endif
            end
         end
         S_RUN: begin
            if (issue) begin
               if (at_last) begin
                  state_d = S_DRAIN;
               end else begin
`ifdef SIGN_SCALE2_EN
                  // Each address twice, each row twice, before the row base moves on.
                  rx_d = ~rx_q;
                  if (rx_q) begin
                     if (x_end) begin
                        x_d  = '0;
                        ry_d = ~ry_q;
                        if (ry_q) begin
                           y_d   = y_q + 1'b1;
                           row_d = row_q + ADDR_WIDTH'(IMG_W);
                        end
                     end else begin
                        x_d = x_q + 1'b1;
                     end
                  end
`else
                  if (x_end) begin
                     x_d   = '0;
                     y_d   = y_q + 1'b1;
                     row_d = row_q + ADDR_WIDTH'(IMG_W);
                  end else begin
                     x_d = x_q + 1'b1;
                  end
`endif
                  addr_d = row_d + ADDR_WIDTH'(x_d);
               end
            end
         end
         S_DRAIN: begin
            if (pop && l0_q) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Head always sits in entry 0; entry 1 only holds data while two pixels are buffered.
   always_comb begin
      cnt_d = cnt_q;
      d0_d  = d0_q;
      d1_d  = d1_q;
      l0_d  = l0_q;
      l1_d  = l1_q;
      case (cnt_q)
         2'd0: begin
            if (push) begin
               d0_d  = push_data;
               l0_d  = infl_last_q;
               cnt_d = 2'd1;
            end
         end
         2'd1: begin
            if (push && pop) begin
               d0_d = push_data;
               l0_d = infl_last_q;
            end else if (push) begin
               d1_d  = push_data;
               l1_d  = infl_last_q;
               cnt_d = 2'd2;
            end else if (pop) begin
               cnt_d = 2'd0;
            end
         end
         default: begin
            if (pop) begin
               d0_d = d1_q;
               l0_d = l1_q;
               if (push) begin
                  d1_d = push_data;
                  l1_d = infl_last_q;
               end else begin
                  cnt_d = 2'd1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         row_q       <= '0;
         addr_q      <= '0;
`ifdef SIGN_SCALE2_EN
         rx_q        <= 1'b0;
         ry_q        <= 1'b0;
`endif
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
         cnt_q       <= '0;
         d0_q        <= '0;
         d1_q        <= '0;
         l0_q        <= 1'b0;
         l1_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         row_q       <= row_d;
         addr_q      <= addr_d;
`ifdef SIGN_SCALE2_EN
         rx_q        <= rx_d;
         ry_q        <= ry_d;
`endif
         infl_q      <= infl_d;
         infl_last_q <= infl_last_d;
         cnt_q       <= cnt_d;
         d0_q        <= d0_d;
         d1_q        <= d1_d;
         l0_q        <= l0_d;
         l1_q        <= l1_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign rom_addr  = addr_q;
   assign pix_valid = (cnt_q != 2'd0);
   assign pix_data  = d0_q;
   assign pix_last  = l0_q & pix_valid;

endmodule

// File: tb/tb_lcd_sign_render.sv
// Bench for lcd_sign_render on a 4x3 bitmap; expectations come from a raster/scale model of the frame.
module tb_lcd_sign_render;

   localparam int W      = 4;
   localparam int H      = 3;
   localparam int NROM   = W * H;
`ifdef SIGN_SCALE2_EN
   localparam int NPIX   = 4 * NROM;
   localparam int FROZEN = 1;
`else
   localparam int NPIX   = NROM;
   localparam int FROZEN = 2;
`endif
   localparam int BUDGET = 600;

   logic        clk = 1'b0;
   logic        rst, start, rom_data, pix_ready;
   logic        busy, done, pix_valid, pix_last;
   logic [16:0] rom_addr;
   logic [15:0] pix_data;

   logic        rom_bits [16];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   lcd_sign_render #(
      .IMG_W(W),
      .IMG_H(H)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .pix_data (pix_data),
      .pix_valid(pix_valid),
      .pix_ready(pix_ready),
      .pix_last (pix_last)
   );

   // External ROM: one-cycle synchronous read.
   always @(posedge clk)
      rom_data <= (rom_addr < 17'(NROM)) ? rom_bits[rom_addr[3:0]] : 1'b0;

   function automatic logic [15:0] exp_pix(input int p);
      int ox, oy;
`ifdef SIGN_SCALE2_EN
      ox = (p % (2 * W)) / 2;
      oy = (p / (2 * W)) / 2;
`else
      ox = p % W;
      oy = p / W;
`endif
      return rom_bits[4'(oy * W + ox)] ? 16'hFFE0 : 16'h0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_reset();
      check("rst_busy",  32'(busy),      32'd0);
      check("rst_done",  32'(done),      32'd0);
      check("rst_addr",  32'(rom_addr),  32'd0);
      check("rst_valid", 32'(pix_valid), 32'd0);
      check("rst_data",  32'(pix_data),  32'd0);
      check("rst_last",  32'(pix_last),  32'd0);
   endtask

   // mode 0: ready high; 1: ready 1,0,0,1...; 2: ready low for 10 cycles; 3: random ready
   task automatic run_frame(input int mode, input int rst_at, input int restart_at);
      int   got = 0, dones = 0, first_v = -1, done_c = -1;
      bit   prev_stall = 0, restarted = 0, fin = 0;
      logic [15:0] prev_d = '0;
      logic        prev_l = 1'b0;
      for (int c = 0; c < BUDGET && !fin; c++) begin
         @(negedge clk);
         if (rst_at >= 0 && got == rst_at) begin
            start = 1'b0; pix_ready = 1'b0; rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_reset();
            return;
         end
         start = (c == 0);
         if (restart_at >= 0 && got == restart_at && !restarted) begin
            start = 1'b1;
            restarted = 1;
         end
         case (mode)
            0: pix_ready = 1'b1;
            1: pix_ready = ((c % 4) == 0) || ((c % 4) == 3);
            2: pix_ready = (c >= 10);
            default: pix_ready = 1'($urandom_range(0, 1));
         endcase
         if (c == 0) check("busy_idle", 32'(busy), 32'd0);
         if (c == 1) check("busy_set",  32'(busy), 32'd1);
         check("addr_range", 32'(rom_addr < 17'(NROM)), 32'd1);
         if (prev_stall) begin
            check("stall_data_stable", 32'(pix_data), 32'(prev_d));
            check("stall_last_stable", 32'(pix_last), 32'(prev_l));
         end
         if (mode == 2 && c >= 4 && c < 10) begin
            check("hold_valid", 32'(pix_valid), 32'd1);
            check("hold_addr",  32'(rom_addr),  32'(FROZEN));
            check("hold_data",  32'(pix_data),  32'(exp_pix(0)));
         end
         if (pix_valid && first_v < 0) first_v = c;
         if (pix_valid && pix_ready) begin
            check("pix_data", 32'(pix_data), 32'(exp_pix(got)));
            check("pix_last", 32'(pix_last), 32'(got == NPIX - 1));
            got++;
         end
         if (done) begin
            dones++;
            done_c = c;
            check("done_after_all", 32'(got),  32'(NPIX));
            check("busy_at_done",   32'(busy), 32'd0);
         end
         if (done_c >= 0 && c >= done_c + 8) fin = 1;
         prev_stall = pix_valid && !pix_ready;
         prev_d     = pix_data;
         prev_l     = pix_last;
      end
      start = 1'b0;
      check("done_count", 32'(dones), 32'd1);
      check("pix_count",  32'(got),   32'(NPIX));
      if (mode == 0) begin
         check("first_latency", 32'(first_v), 32'd3);
         check("done_cycle",    32'(done_c),  32'(3 + NPIX));
      end
   endtask

   initial begin
      logic [11:0] pat;
      pat = 12'b101100111000;
      for (int i = 0; i < 16; i++) rom_bits[i] = 1'b0;
      for (int i = 0; i < NROM; i++) rom_bits[i] = pat[11 - i];
      rst = 1'b1; start = 1'b0; pix_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset();

      run_frame(0, -1, -1);
      run_frame(1, -1, -1);
      run_frame(2, -1, -1);
      run_frame(0, 5, -1);
      run_frame(0, -1, -1);
      run_frame(0, -1, 4);
      run_frame(3, -1, -1);

      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < NROM; i++) rom_bits[i] = 1'($urandom_range(0, 1));
         run_frame(3, -1, -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lcd_sign_render.md
# lcd_sign_render

Streaming pixel renderer placed directly upstream of the 1-bit sign bitmap ROM (17-bit address, 1-bit data, one-cycle synchronous read) and downstream-feeding the LCD write driver. On a start pulse it walks the bitmap in raster order, issues one ROM address per output pixel and expands each returned bit to an RGB565 colour. Pixels leave on a valid/ready stream. A two-entry output buffer absorbs the ROM read latency so backpressure never loses a pixel.

## Interface
- IMG_W, 320: bitmap width in pixels
- IMG_H, 240: bitmap height in pixels; IMG_W*IMG_H ≤ 2^ADDR_WIDTH
- ADDR_WIDTH, 17: ROM address width
- FG_COLOR, 16'hFFE0: RGB565 colour for bit = 1
- BG_COLOR, 16'h0000: RGB565 colour for bit = 0

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to render a frame
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last pixel handshake
- rom_addr  out  ADDR_WIDTH  registered ROM address
- rom_data  in  1  ROM output, valid the cycle after rom_addr is presented
- pix_data  out  16  RGB565 pixel
- pix_valid  out  1  pix_data valid
- pix_ready  in  1  downstream accepts when high with pix_valid
- pix_last  out  1  high with the final pixel of the frame

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE: start → RUN. Counters are cleared at the transition.
  - RUN: issues addresses. After the last address is issued → DRAIN.
  - DRAIN: waits for the last pixel handshake, pulses done, → IDLE.
- start is ignored while busy.
- Address generation:
  - x/y counters, with a row base that accumulates +IMG_W per row. No multiplier.
  - rom_addr = row_base + x, raster order, 0 … IMG_W*IMG_H−1.
- Issue rule: a new address is issued in a cycle only if (fifo_count + inflight − pop) < 2, where pop = pix_valid & pix_ready.
  - This gives one pixel per cycle under continuous pix_ready.
  - It also guarantees the buffer never overflows.
- inflight is set the cycle an address is issued. The next cycle, rom_data is converted (1 → FG_COLOR, 0 → BG_COLOR) and written to the buffer together with its last flag.
- Buffer: 2-entry FIFO. Simultaneous push and pop are allowed at any occupancy, including full with a pop.
- pix_valid = buffer not empty. pix_data and pix_last come from the head entry.
- pix_data and pix_last stay stable while pix_valid & !pix_ready.
- Reset values: busy 0, done 0, rom_addr 0, pix_valid 0, pix_data 0, pix_last 0, state IDLE, buffer empty, inflight 0.
- Reset mid-frame discards the outstanding ROM read and all buffered pixels; the next start begins at address 0.

## Timing
- start sampled at edge E0 → busy=1 and rom_addr=0 after E1 → ROM data after E2 → buffer write at E3 → pix_valid=1 after E3.
- First-pixel latency: 3 cycles.
- Throughput: 1 pixel/cycle with pix_ready held high. Frame = IMG_W*IMG_H handshakes.
- done pulses in the cycle after the pix_last handshake. busy drops in that same cycle.
- A new start is accepted one cycle after done, or later.
- Stalls: while pix_ready=0 and the buffer is full, rom_addr holds and no address is issued.

## Configuration
- SIGN_SCALE2_EN defined:
  - Output frame is 2*IMG_W × 2*IMG_H.
  - Each bit is emitted as a 2×2 block: each address is issued twice consecutively, and each row's address sequence is issued twice before row_base advances.
  - pix_last marks output pixel 4*IMG_W*IMG_H−1.
- SIGN_SCALE2_EN undefined: 1:1 mapping as described above, with no scaling logic present.

## Test plan
- IMG_W=4, IMG_H=3, ROM model holding bits 101100111000; start with pix_ready=1.
  - Expect 12 pixels FFE0,0000,FFE0,FFE0,0000,0000,FFE0,FFE0,FFE0,0000,0000,0000 on consecutive cycles.
  - First pix_valid 3 cycles after start; pix_last on pixel 12; done the next cycle.
- Same frame with pix_ready toggling 1,0,0,1 repeating.
  - Expect an identical 12-pixel sequence, no duplicates or drops, pix_data stable during every stall, rom_addr never exceeding 11.
- pix_ready=0 for 10 cycles after start.
  - Expect pix_valid=1 with pixel 0 held; exactly 2 buffered entries; rom_addr frozen at 2 until release.
- rst asserted after pixel 5 handshake, then start again.
  - Expect all outputs at reset values in the cycle after rst; the new frame restarts at address 0 with pixel FFE0.
- start pulsed again while busy (pixel 4).
  - Expect it ignored; exactly one done; 12 pixels total.
- With SIGN_SCALE2_EN, IMG_W=2, IMG_H=1, bits 10.
  - Expect rom_addr sequence 0,0,1,1,0,0,1,1.
  - Expect pixels FFE0,FFE0,0000,0000 twice; pix_last on pixel 8.
